// File: rtl/water_supply_arbiter.sv
// Round-robin arbiter sharing one mains water inlet between N washing-machine controllers.
// Each grant is capped at MAX_GRANT cycles, and consecutive grants are separated by GAP_CYCLES of dead time.
module water_supply_arbiter #(
  parameter int N          = 4,
  parameter int MAX_GRANT  = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req_i,
  input  logic                 inhibit_i,
  output logic [N-1:0]         grant_o,
  output logic [$clog2(N)-1:0] grantIdx_o,
  output logic                 valveOn_o,
  output logic                 timeout_o
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(MAX_GRANT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gapCnt_q, gapCnt_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] grantIdx_q, grantIdx_d;
  logic             valveOn_q, valveOn_d;
  logic             timeout_q, timeout_d;

  logic             winFound;
  logic [IDX_W-1:0] winIdx;
  logic [IDX_W-1:0] cand;
  logic             forceRel;

  // Rotating priority search: the first requester at or after ptr wins.
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % N);
      if (!winFound && req_i[cand]) begin
        winFound = 1'b1;
        winIdx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      gapCnt_q   <= '0;
      grant_q    <= '0;
      grantIdx_q <= '0;
      valveOn_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      gapCnt_q   <= gapCnt_d;
      grant_q    <= grant_d;
      grantIdx_q <= grantIdx_d;
      valveOn_q  <= valveOn_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gapCnt_d = gapCnt_q;
    forceRel = 1'b0;
    case (state_q)
      IDLE: begin
        if (winFound && !inhibit_i) begin
          state_d = GRANT;
          owner_d = winIdx;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        // A dropped request or an inhibit outranks the cap, so neither counts as a timeout.
        if (inhibit_i || !req_i[owner_q] || cnt_q == CNT_W'(MAX_GRANT)) begin
          forceRel = !inhibit_i && req_i[owner_q];
          state_d  = GAP;
          ptr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
          gapCnt_d = GAP_W'(GAP_CYCLES);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gapCnt_q > GAP_W'(1)) begin
          gapCnt_d = gapCnt_q - 1'b1;
        end else if (winFound && !inhibit_i) begin
          state_d = GRANT;
          owner_d = winIdx;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d    = '0;
    grantIdx_d = '0;
    valveOn_d  = 1'b0;
    timeout_d  = forceRel;
    if (state_d == GRANT) begin
      grant_d[owner_d] = 1'b1;
      grantIdx_d       = owner_d;
      valveOn_d        = 1'b1;
    end
  end

  assign grant_o    = grant_q;
  assign grantIdx_o = grantIdx_q;
  assign valveOn_o  = valveOn_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_water_supply_arbiter.sv
// Bench for water_supply_arbiter: a busy/gap-countdown model checked every cycle,
// plus literal checkpoints that pin the model against hand-computed scenarios.
module tb_water_supply_arbiter;

  localparam int N          = 4;
  localparam int MAX_GRANT  = 4;
  localparam int GAP_CYCLES = 1;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         inhibit;
  logic [N-1:0] grant;
  logic [1:0]   grantIdx;
  logic         valveOn;
  logic         timeout;

  int compared   = 0;
  int mismatched = 0;

  water_supply_arbiter #(.N(N), .MAX_GRANT(MAX_GRANT), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .inhibit_i  (inhibit),
    .grant_o    (grant),
    .grantIdx_o (grantIdx),
    .valveOn_o  (valveOn),
    .timeout_o  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit mValid = 0;
  bit mBusy;
  bit mTimeout;
  bit mPicked;
  int mOwner, mHeld, mGapLeft, mPtr, mK;

  // Model: a machine is either holding the supply or not; when it is idle,
  // mGapLeft counts the dead cycles still owed before anyone may be picked.
  always @(posedge clk) begin
    if (reset) begin
      mValid = 1; mBusy = 0; mOwner = 0; mHeld = 0; mGapLeft = 0; mPtr = 0; mTimeout = 0;
    end else if (mValid) begin
      mTimeout = 0;
      if (mBusy) begin
        if (inhibit || !req[mOwner] || mHeld == MAX_GRANT) begin
          mTimeout = !inhibit && req[mOwner];
          mBusy    = 0;
          mPtr     = (mOwner + 1) % N;
          mGapLeft = GAP_CYCLES;
        end else begin
          mHeld++;
        end
      end else begin
        mPicked = 0;
        if (mGapLeft <= 1 && !inhibit) begin
          for (int s = 0; s < N; s++) begin
            mK = (mPtr + s) % N;
            if (!mPicked && req[mK]) begin
              mPicked = 1;
              mBusy   = 1;
              mOwner  = mK;
              mHeld   = 1;
            end
          end
        end
        if (mGapLeft > 0) mGapLeft--;
      end
    end
  end

  task automatic compareField(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mValid) begin
      compareField("modelGrant", 32'(grant), mBusy ? (32'd1 << mOwner) : 32'd0);
      compareField("modelGrantIdx", 32'(grantIdx), mBusy ? 32'(mOwner) : 32'd0);
      compareField("modelValveOn", 32'(valveOn), 32'(mBusy));
      compareField("modelTimeout", 32'(timeout), 32'(mTimeout));
    end
  end

  task automatic applyStimulus(input logic [N-1:0] r, input logic inh, input logic rst, input int cycles);
    req     = r;
    inhibit = inh;
    reset   = rst;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] g, input logic [1:0] idx,
                             input logic v, input logic t);
    compareField({name, ".grant"}, 32'(grant), 32'(g));
    compareField({name, ".grantIdx"}, 32'(grantIdx), 32'(idx));
    compareField({name, ".valveOn"}, 32'(valveOn), 32'(v));
    compareField({name, ".timeout"}, 32'(timeout), 32'(t));
  endtask

  initial begin
    applyStimulus(4'b0000, 1'b0, 1'b1, 3);
    checkOutput("resetState", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Single request, then drop: grant lasts one cycle past the drop.
    applyStimulus(4'b0100, 1'b0, 1'b0, 1);
    checkOutput("singleGrant", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1);
    checkOutput("singleDrop", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1);

    // Lone requester times out and is re-granted after the gap.
    applyStimulus(4'b0001, 1'b0, 1'b0, 4);
    checkOutput("capHeld", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1);
    checkOutput("capTimeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1);
    checkOutput("regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 3);
    checkOutput("regrantHeld", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0001, 1'b0, 1'b0, 1);
    checkOutput("regrantTimeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2);

    // Full contention from a fresh reset: 0,1,2,3,0.
    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    for (int g = 0; g < 5; g++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 1);
      checkOutput("rrStart", 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b0, 1'b0, 3);
      checkOutput("rrHeld", 4'(1 << (g % 4)), 2'(g % 4), 1'b1, 1'b0);
      applyStimulus(4'b1111, 1'b0, 1'b0, 1);
      checkOutput("rrTimeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 2);

    // Drop on the cap edge: plain release, ptr moves to 2.
    applyStimulus(4'b0010, 1'b0, 1'b0, 4);
    checkOutput("dropAtCapHeld", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1);
    checkOutput("dropAtCap", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0111, 1'b0, 1'b0, 1);
    checkOutput("ptrAfterDrop", 4'b0100, 2'd2, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2);

    // Inhibit revokes the grant and blocks arbitration; ptr wraps to 0.
    applyStimulus(4'b1000, 1'b0, 1'b0, 1);
    checkOutput("inhGrant", 4'b1000, 2'd3, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 1);
    checkOutput("inhRevoke", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b1, 1'b0, 4);
    checkOutput("inhBlocked", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b1001, 1'b0, 1'b0, 1);
    checkOutput("inhResume", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2);

    // Reset mid-grant clears everything, including ptr.
    applyStimulus(4'b0010, 1'b0, 1'b0, 1);
    checkOutput("preReset", 4'b0010, 2'd1, 1'b1, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b1, 1);
    checkOutput("midReset", 4'b0000, 2'd0, 1'b0, 1'b0);
    applyStimulus(4'b0011, 1'b0, 1'b0, 1);
    checkOutput("postReset", 4'b0001, 2'd0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/water_supply_arbiter.md
# water_supply_arbiter

Round-robin arbiter that shares one mains water inlet between `N` washing-machine controllers in a multi-machine installation. Each controller raises a fill request in place of driving its own inlet valve. The arbiter grants the supply to one machine at a time and caps each grant at `MAX_GRANT` cycles. It inserts `GAP_CYCLES` of dead time between grants so the valve manifold can switch over. It sits between the per-machine controllers' `input_valve` outputs and the physical inlet/manifold drivers.

## Interface
- `N`, 4, number of requesting machines (≥2)
- `MAX_GRANT`, 4, maximum consecutive cycles one grant may be held (≥1)
- `GAP_CYCLES`, 1, cycles with all grants low between two grants (≥1)
- `clk` input 1: single clock. Reset is synchronous and active-high.
- `reset` input 1: synchronous, active-high; all state cleared on the clock edge where it is sampled high.
- `req` input N: per-machine fill request, level; bit k belongs to machine k.
- `inhibit` input 1: supply fault/maintenance; blocks new grants and revokes the active grant.
- `grant` output N: one-hot or zero, registered; drives manifold valve k.
- `grant_idx` output clog2(N): index of granted machine; 0 when no grant.
- `valve_on` output 1: registered, equals the OR of `grant`; drives the mains inlet.
- `timeout` output 1: one-cycle pulse; the previous grant was force-released at `MAX_GRANT`.

## Operation
- Registers:
  - `state` ∈ {IDLE, GRANT, GAP}
  - `ptr` (clog2(N) bits): round-robin start point
  - `owner`: current grantee
  - `cnt` (clog2(MAX_GRANT+1) bits)
  - `gap_cnt` (clog2(GAP_CYCLES+1) bits)
- Reset values:
  - `state`=IDLE, `ptr`=0, `cnt`=0, `gap_cnt`=0
  - `grant`=0, `grant_idx`=0, `valve_on`=0, `timeout`=0
- Arbitration (evaluated in IDLE, and on the last GAP edge):
  - Search order is `ptr`, `ptr`+1, …, N-1, 0, …, `ptr`-1 (modulo N).
  - The first k with `req[k]`=1 wins.
  - On a win: `grant`←one-hot(k), `grant_idx`←k, `valve_on`←1, `cnt`←1, `state`←GRANT.
  - No arbitration happens while `inhibit`=1.
- GRANT, each edge, priority order:
  1. `inhibit`=1: release, `timeout`←0.
  2. `req[owner]`=0: release, `timeout`←0. This takes priority even when `cnt`=MAX_GRANT.
  3. `cnt`=MAX_GRANT: release, `timeout`←1.
  4. Otherwise: `cnt`←`cnt`+1.
- Release means:
  - `grant`←0, `grant_idx`←0, `valve_on`←0
  - `ptr`←(owner+1) mod N
  - `gap_cnt`←GAP_CYCLES, `state`←GAP
- GAP, each edge:
  - If `gap_cnt`>1: decrement `gap_cnt`.
  - If `gap_cnt`=1: arbitrate as in IDLE. With no winner (or `inhibit`=1), go to IDLE.
- IDLE: arbitrate every edge. `timeout` is cleared on every edge that does not force-release.
- `req` changes on non-owner bits never affect the current grant; they only matter at the next arbitration.
- `ptr` changes only on release. The new `ptr` is `owner`+1 wrapping N-1→0, whether the release came from request drop, timeout or inhibit.
- A lone requester is re-granted after the gap even though `ptr` has moved past it.

## Timing
- Request-to-grant latency from IDLE: `req` sampled high at edge e, `grant` visible in the cycle after e (1 cycle).
- Grant duration:
  - At most MAX_GRANT cycles of `grant` high per grant.
  - If `req` falls, `grant` stays high for exactly one more cycle.
- Switch-over: between any two grants, `grant`=0 for exactly GAP_CYCLES cycles when a requester is waiting.
- `timeout` is high exactly in the first GAP cycle following a forced release.
- `inhibit` is sampled like `req`. The grant drops the cycle after `inhibit` is sampled high. Arbitration resumes on the first edge after both `inhibit`=0 and any remaining GAP cycles have elapsed.
- Reset mid-operation (any state): on the reset edge all outputs go to their reset values and `ptr`=0. The first grant after reset release needs `req` sampled high at a later edge.

## Test plan
- **Single request:** reset 3 cycles, then `req`=4'b0100 → one cycle later `grant`=4'b0100, `grant_idx`=2, `valve_on`=1. Drop `req` → `grant`=0 one cycle after the drop, no `timeout`.
- **Timeout and re-grant:** `req[0]` held high 12 cycles → `grant[0]` high exactly 4 cycles, `timeout`=1 for 1 cycle with `grant`=0, then `grant[0]` high again for 4 cycles.
- **Full contention:** `req`=4'b1111 continuously → grant sequence 0,1,2,3,0 (ptr wraps 3→0), each 4 cycles, separated by exactly 1 zero-grant cycle, `timeout` pulsing after each.
- **Request drop at the cap:** `req[1]` granted and dropped on the same edge where `cnt`=4 → release with `timeout`=0, `ptr`=2.
- **Inhibit:** `req`=4'b1000 granted, `inhibit` pulsed high for 5 cycles → `grant`=0 the next cycle, no grant while `inhibit`=1. With `req`=4'b1001 after `inhibit` falls, machine 0 wins (ptr=0 after wrap).
- **Reset mid-grant:** `req`=4'b0010 granted, assert `reset` one edge → `grant`=0, `grant_idx`=0, `valve_on`=0, `timeout`=0 next cycle. After release, `req`=4'b0011 → machine 0 wins (ptr reset to 0).
